// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave exposing read-only status words, read/write configuration words and an
// interrupt pending (write-1-to-clear) / enable pair; unmapped or illegal accesses return SLVERR.
module axi_lite_regbank #(
    parameter int C_S_AXI_REG_DWIDTH = 32,
    parameter int C_S_AXI_REG_AWIDTH = 6,
    parameter int C_NUM_RO           = 2,
    parameter int C_NUM_RW           = 4,
    parameter int C_NUM_IRQ          = 8
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [C_NUM_RO*C_S_AXI_REG_DWIDTH-1:0]   CORE_STATUS,
    output logic [C_NUM_RW*C_S_AXI_REG_DWIDTH-1:0]   CORE_CFG,
    output logic [C_NUM_RW-1:0]                      CORE_CFG_WE,
    input  logic [C_NUM_IRQ-1:0]                     CORE_EVT,
    output logic                                     IRQ,
    input  logic [C_S_AXI_REG_AWIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_REG_DWIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_REG_DWIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_REG_AWIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_REG_DWIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY
);

    localparam int DW       = C_S_AXI_REG_DWIDTH;
    localparam int AW       = C_S_AXI_REG_AWIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = AW - ADDR_LSB;

    localparam logic [IDX_W-1:0] PEND_IDX = IDX_W'(C_NUM_RO + C_NUM_RW);
    localparam logic [IDX_W-1:0] EN_IDX   = IDX_W'(C_NUM_RO + C_NUM_RW + 1);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    logic                        rdyEn_q;
    logic [C_NUM_RO*DW-1:0]      status_q;
    logic [C_NUM_RW*DW-1:0]      cfg_q,   cfg_d;
    logic [C_NUM_RW-1:0]         cfgWe_q, cfgWe_d;
    logic [C_NUM_IRQ-1:0]        pend_q,  pend_d;
    logic [C_NUM_IRQ-1:0]        en_q,    en_d;
    logic                        irq_q,   irq_d;
    logic                        awHeld_q, awHeld_d;
    logic [IDX_W-1:0]            awIdx_q,  awIdx_d;
    logic                        wHeld_q,  wHeld_d;
    logic [DW-1:0]               wData_q,  wData_d;
    logic [NB-1:0]               wStrb_q,  wStrb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q,  bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q,  rresp_d;
    logic [DW-1:0]               rdata_q,  rdata_d;

    logic                        awReady, wReady, arReady, commit;
    logic [DW-1:0]               strbMask;
    logic [C_NUM_IRQ-1:0]        w1cClr;
    logic [IDX_W-1:0]            arIdx;
    logic [DW-1:0]               rdWord;
    logic                        rdErr;
    logic                        unusedBits;

    assign unusedBits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign awReady = rdyEn_q & ~awHeld_q & ~bvalid_q;
    assign wReady  = rdyEn_q & ~wHeld_q & ~bvalid_q;
    assign arReady = rdyEn_q & ~rvalid_q;
    assign commit  = awHeld_q & wHeld_q;
    assign arIdx   = S_AXI_ARADDR[AW-1:ADDR_LSB];

    always_comb begin
        strbMask = '0;
        for (int b = 0; b < NB; b++) begin
            strbMask[b*8 +: 8] = {8{wStrb_q[b]}};
        end
    end

    // AW and W each park in their own holding slot; the write is applied once both are present.
    always_comb begin
        awHeld_d = awHeld_q;
        awIdx_d  = awIdx_q;
        wHeld_d  = wHeld_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        if (commit) begin
            awHeld_d = 1'b0;
            wHeld_d  = 1'b0;
        end
        if (S_AXI_AWVALID && awReady) begin
            awHeld_d = 1'b1;
            awIdx_d  = S_AXI_AWADDR[AW-1:ADDR_LSB];
        end
        if (S_AXI_WVALID && wReady) begin
            wHeld_d = 1'b1;
            wData_d = S_AXI_WDATA;
            wStrb_d = S_AXI_WSTRB;
        end
    end

    always_comb begin
        cfg_d    = cfg_q;
        cfgWe_d  = '0;
        en_d     = en_q;
        w1cClr   = '0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            for (int k = 0; k < C_NUM_RW; k++) begin
                if (awIdx_q == IDX_W'(C_NUM_RO + k)) begin
                    cfg_d[k*DW +: DW] = (cfg_q[k*DW +: DW] & ~strbMask) | (wData_q & strbMask);
                    cfgWe_d[k]        = 1'b1;
                    bresp_d           = RESP_OKAY;
                end
            end
            if (awIdx_q == PEND_IDX) begin
                w1cClr  = wData_q[C_NUM_IRQ-1:0] & strbMask[C_NUM_IRQ-1:0];
                bresp_d = RESP_OKAY;
            end
            if (awIdx_q == EN_IDX) begin
                en_d    = (en_q & ~strbMask[C_NUM_IRQ-1:0])
                        | (wData_q[C_NUM_IRQ-1:0] & strbMask[C_NUM_IRQ-1:0]);
                bresp_d = RESP_OKAY;
            end
        end
    end

    // A new event outranks a simultaneous write-1-to-clear of the same bit.
    assign pend_d = (pend_q & ~w1cClr) | CORE_EVT;
    assign irq_d  = |(pend_q & en_q);

    always_comb begin
        rdWord = '0;
        rdErr  = 1'b1;
        for (int k = 0; k < C_NUM_RO; k++) begin
            if (arIdx == IDX_W'(k)) begin
                rdWord = status_q[k*DW +: DW];
                rdErr  = 1'b0;
            end
        end
        for (int k = 0; k < C_NUM_RW; k++) begin
            if (arIdx == IDX_W'(C_NUM_RO + k)) begin
                rdWord = cfg_q[k*DW +: DW];
                rdErr  = 1'b0;
            end
        end
        if (arIdx == PEND_IDX) begin
            rdWord[C_NUM_IRQ-1:0] = pend_q;
            rdErr                 = 1'b0;
        end
        if (arIdx == EN_IDX) begin
            rdWord[C_NUM_IRQ-1:0] = en_q;
            rdErr                 = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (S_AXI_ARVALID && arReady) begin
            rvalid_d = 1'b1;
            rdata_d  = rdWord;
            rresp_d  = rdErr ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdyEn_q  <= 1'b0;
            status_q <= '0;
            cfg_q    <= '0;
            cfgWe_q  <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            irq_q    <= 1'b0;
            awHeld_q <= 1'b0;
            awIdx_q  <= '0;
            wHeld_q  <= 1'b0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rdyEn_q  <= 1'b1;
            status_q <= CORE_STATUS;
            cfg_q    <= cfg_d;
            cfgWe_q  <= cfgWe_d;
            pend_q   <= pend_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
            awHeld_q <= awHeld_d;
            awIdx_q  <= awIdx_d;
            wHeld_q  <= wHeld_d;
            wData_q  <= wData_d;
            wStrb_q  <= wStrb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign CORE_CFG      = cfg_q;
    assign CORE_CFG_WE   = cfgWe_q;
    assign IRQ           = irq_q;
    assign S_AXI_AWREADY = awReady;
    assign S_AXI_WREADY  = wReady;
    assign S_AXI_ARREADY = arReady;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule
